aes_block_loader: RTL



---
 rtl/aes_block_loader_pkg.sv | 19 +
 rtl/aes_word_packer.sv | 46 ++++
 rtl/aes_block_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_block_loader_pkg.sv
// Shared types and constants for the AES-128 block loader.
package aes_block_loader_pkg;

   localparam int AES_WORDS_PER_BLOCK = 4;
   // Launch-to-done cycles of the iterative AES-128 core.
   localparam int AES_CORE_LATENCY    = 11;
   // Watchdog default: core latency plus a few cycles of slack.
   localparam int AES_TIMEOUT_DEFAULT = AES_CORE_LATENCY + 5;

   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_word_t;

   // Whether the core has an encryption in flight.
   typedef enum logic {
      CORE_IDLE = 1'b0,
      CORE_BUSY = 1'b1
   } core_state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Packs four 32-bit stream words into one 128-bit block. The first word of a
// block lands in bits [127:96]. Once the block is full, input is stalled until
// the block is consumed.
module aes_word_packer
   import aes_block_loader_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         consume,
   output logic [127:0] block,
   output logic         full
);

   logic [1:0] word_cnt;
   logic [1:0] lane;
   logic       accept;

   assign s_ready = !full;
   assign accept  = s_valid && s_ready;
   assign lane    = 2'd3 - word_cnt;

   // Word capture, word counting and full flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_cnt <= 2'd0;
         full     <= 1'b0;
         // NOTE: the buffer is reset as well, so a reset never lets a stale partial block leak into a later launch.
         block    <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample pre-edge values, so ordering inside the block does not matter.
         if (accept) begin
            block[32*lane +: 32] <= s_data;
            word_cnt             <= word_cnt + 2'd1;
            if (word_cnt == 2'(AES_WORDS_PER_BLOCK - 1)) begin
               full <= 1'b1;
            end
         end else if (consume) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/aes_block_loader.sv
// Upstream feeder for the iterative AES-128 core. It packs stream words into
// blocks, holds the key, and launches a block only while the core is idle.
// A watchdog recovers the core state if the done strobe never arrives.
module aes_block_loader
   import aes_block_loader_pkg::*;
#(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = AES_TIMEOUT_DEFAULT,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              key_wr,
   input  logic [127:0]      key_data,
   output logic              aes_valid_o,
   output logic [127:0]      aes_data_o,
   output logic [127:0]      aes_key_o,
   input  logic              aes_done_i,
   output logic              busy_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  blk_cnt_o
);

   localparam int WD_W = $clog2(TIMEOUT);

   core_state_t     state;
   logic            key_set;
   logic            buf_full;
   logic [127:0]    buf_block;
   logic            launch;
   logic [WD_W-1:0] wd_cnt;

   assign launch = buf_full && (state == CORE_IDLE) && key_set;
   assign busy_o = (state == CORE_BUSY);

   aes_word_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .consume (launch),
      .block   (buf_block),
      .full    (buf_full)
   );

   // Key register; a write at a launch edge is seen by the core on that launch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aes_key_o <= '0;
         key_set   <= 1'b0;
      end else if (key_wr) begin
         aes_key_o <= key_data;
         key_set   <= 1'b1;
      end
   end

   // Launch strobe, launched block and launch counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aes_valid_o <= 1'b0;
         aes_data_o  <= '0;
         blk_cnt_o   <= '0;
      end else begin
         aes_valid_o <= launch;
         if (launch) begin
            aes_data_o <= buf_block;
            blk_cnt_o  <= blk_cnt_o + CNT_W'(1);
         end
      end
   end

   // Core tracking FSM with watchdog; a timeout frees the core and latches err_o.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= CORE_IDLE;
         wd_cnt <= '0;
         err_o  <= 1'b0;
      end else begin
         case (state)
            CORE_IDLE: begin
               if (launch) begin
                  state  <= CORE_BUSY;
                  wd_cnt <= '0;
               end
            end
            CORE_BUSY: begin
               if (aes_done_i) begin
                  state  <= CORE_IDLE;
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  state  <= CORE_IDLE;
                  wd_cnt <= '0;
                  err_o  <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= CORE_IDLE;
         endcase
      end
   end

endmodule
